// File: rtl/mem_bist_ctrl_if.sv
// Request/response port between the BIST controller and the SRAM model.
// The controller holds the request stable while valid=1 and ready=0; rdata is valid on a completing read.
interface mem_bist_ctrl_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 5
) ();
   logic                  valid;
   logic                  ready;
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic [WIDTH-1:0]      rdata;

   modport master (output valid, wr_rd, addr, wdata, input ready, rdata);
   modport slave  (input valid, wr_rd, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_bist_ctrl.sv
// March BIST controller: M0 w(BG) up, M1 r(BG)w(~BG) up, M2 r(~BG)w(BG) down, M3 r(BG) up.
// MEM_BIST_ERR_LOG_EN builds the fail_addr/fail_count log; without it only a sticky miscompare flag exists.
module mem_bist_ctrl #(
   parameter int               WIDTH      = 8,
   parameter int               DEPTH      = 32,
   parameter int               ADDR_WIDTH = $clog2(DEPTH),
   parameter logic [WIDTH-1:0] BG         = WIDTH'(8'h55)
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [7:0]            fail_count,
   mem_bist_ctrl_if.master       mem
);

   typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DONE} state_t;

   typedef struct packed {
      logic                  wr_rd;
      logic [ADDR_WIDTH-1:0] addr;
      logic [WIDTH-1:0]      wdata;
   } req_t;

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  phase_q, phase_d;   // M1/M2: 0 = read half, 1 = write half
   logic                  clr;
   logic                  err;

   req_t                  req;
   logic [WIDTH-1:0]      exp_data;
   logic                  fire, miscmp, at_last, at_zero;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         phase_q <= phase_d;
      end
   end

   // Request is decoded from registered state, so it is stable across stalls
   // and collapses to reset values the moment res falls.
   always_comb begin
      req.wr_rd = 1'b0;
      req.addr  = addr_q;
      req.wdata = '0;
      exp_data  = '0;
      case (state_q)
         S_M0: begin
            req.wr_rd = 1'b1;
            req.wdata = BG;
         end
         S_M1: begin
            if (phase_q) begin
               req.wr_rd = 1'b1;
               req.wdata = ~BG;
            end else begin
               exp_data = BG;
            end
         end
         S_M2: begin
            if (phase_q) begin
               req.wr_rd = 1'b1;
               req.wdata = BG;
            end else begin
               exp_data = ~BG;
            end
         end
         S_M3:    exp_data = BG;
         default: ;
      endcase
   end

   assign busy      = (state_q == S_M0) || (state_q == S_M1) ||
                      (state_q == S_M2) || (state_q == S_M3);
   assign done      = (state_q == S_DONE);
   assign mem.valid = busy;
   assign mem.wr_rd = req.wr_rd;
   assign mem.addr  = req.addr;
   assign mem.wdata = req.wdata;

   assign fire    = mem.valid & mem.ready;
   assign miscmp  = fire & ~req.wr_rd & (mem.rdata != exp_data);
   assign at_last = (addr_q == LAST);
   assign at_zero = (addr_q == '0);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      phase_d = phase_q;
      clr     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_M0;
               addr_d  = '0;
               phase_d = 1'b0;
               clr     = 1'b1;
            end
         end
         S_M0: begin
            if (fire) begin
               if (at_last) begin
                  state_d = S_M1;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + ONE;
               end
            end
         end
         S_M1: begin
            if (fire) begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  if (at_last) begin
                     state_d = S_M2;
                     addr_d  = LAST;
                  end else begin
                     addr_d = addr_q + ONE;
                  end
               end
            end
         end
         S_M2: begin
            if (fire) begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  if (at_zero) begin
                     state_d = S_M3;
                     addr_d  = '0;
                  end else begin
                     addr_d = addr_q - ONE;
                  end
               end
            end
         end
         S_M3: begin
            if (fire) begin
               if (at_last) begin
                  state_d = S_DONE;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef MEM_BIST_ERR_LOG_EN
   logic [ADDR_WIDTH-1:0] fail_addr_q;
   logic [7:0]            fail_count_q;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         fail_addr_q  <= '0;
         fail_count_q <= '0;
      end else if (clr) begin
         fail_addr_q  <= '0;
         fail_count_q <= '0;
      end else if (miscmp) begin
         if (fail_count_q == 8'd0) fail_addr_q <= addr_q;
         if (fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
      end
   end

   assign fail_addr  = fail_addr_q;
   assign fail_count = fail_count_q;
   assign err        = (fail_count_q != 8'd0);
`else
   logic err_q;

   always_ff @(posedge clk or negedge res) begin
      if (!res)        err_q <= 1'b0;
      else if (clr)    err_q <= 1'b0;
      else if (miscmp) err_q <= 1'b1;
   end

   assign fail_addr  = '0;
   assign fail_count = '0;
   assign err        = err_q;
`endif

   assign pass = done & ~err;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl: behavioural SRAM with programmable stalls and an addr-5 bit-0 fault.
module tb_mem_bist_ctrl;
   localparam int         W  = 8;
   localparam int         D  = 32;
   localparam int         AW = 5;
   localparam logic [W-1:0] BGV = 8'h55;

   logic          clk = 1'b0;
   logic          res = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, pass;
   logic [AW-1:0] fail_addr;
   logic [7:0]    fail_count;

   int n_tests = 0;
   int n_fail  = 0;

   int stall_n  = 0;
   bit fault_en = 1'b0;
   int scnt     = 0;

   logic [W-1:0]  mem [D];
   logic [AW-1:0] log_addr [$];
   logic          log_wr   [$];
   logic [AW-1:0] exp_addr [$];
   logic          exp_wr   [$];
   int            stab_err   = 0;
   int            stall_seen = 0;
   logic          prev_stall = 1'b0;
   logic [AW+W:0] prev_req   = '0;

   mem_bist_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) mif ();

   mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .BG(BGV)) dut (
      .clk        (clk),
      .res        (res),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .fail_addr  (fail_addr),
      .fail_count (fail_count),
      .mem        (mif)
   );

   always #5 clk = ~clk;

   // Memory model: ready rises after stall_n wait cycles of a pending request.
   assign mif.ready = (scnt >= stall_n);
   assign mif.rdata = mem[mif.addr] ^ ((fault_en && mif.addr == AW'(5)) ? 8'h01 : 8'h00);

   always @(posedge clk) begin
      if (mif.valid && mif.ready) begin
         if (mif.wr_rd) mem[mif.addr] <= mif.wdata;
         scnt <= 0;
      end else if (mif.valid) begin
         scnt <= scnt + 1;
      end else begin
         scnt <= 0;
      end
   end

   // Monitor between edges: logs operations about to complete, checks stall stability.
   always @(negedge clk) begin
      logic [AW+W:0] cur;
      cur = {mif.wr_rd, mif.addr, mif.wdata};
      if (prev_stall && (!mif.valid || cur != prev_req)) stab_err++;
      if (mif.valid && !mif.ready) stall_seen++;
      if (mif.valid && mif.ready) begin
         log_addr.push_back(mif.addr);
         log_wr.push_back(mif.wr_rd);
      end
      prev_stall = mif.valid && !mif.ready;
      prev_req   = cur;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".busy"},       busy,       0);
      chk({tag, ".done"},       done,       0);
      chk({tag, ".pass"},       pass,       0);
      chk({tag, ".fail_addr"},  fail_addr,  0);
      chk({tag, ".fail_count"}, fail_count, 0);
      chk({tag, ".valid"},      mif.valid,  0);
      chk({tag, ".wr_rd"},      mif.wr_rd,  0);
      chk({tag, ".addr"},       mif.addr,   0);
      chk({tag, ".wdata"},      mif.wdata,  0);
   endtask

   // Pulses start, optionally re-pulses it at latency restart_at, and counts
   // edges from the start edge (1) to the edge after which done is visible.
   task automatic run(input string tag, input int stall, input bit flt, input int restart_at,
                      output int lat, output int base);
      stall_n  = stall;
      fault_en = flt;
      base     = log_addr.size();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".first_valid"}, mif.valid, 1);
      chk({tag, ".first_addr"},  mif.addr,  0);
      chk({tag, ".first_wr"},    mif.wr_rd, 1);
      chk({tag, ".first_wdata"}, mif.wdata, BGV);
      while (!done && lat < 2000) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = (lat == restart_at);
      end
      start = 1'b0;
      chk({tag, ".done"}, done, 1);
   endtask

   task automatic chk_seq(input string tag, input int base);
      int errs = 0;
      chk({tag, ".ops"}, log_addr.size() - base, 6 * D);
      for (int i = 0; i < 6 * D; i++) begin
         if (base + i >= log_addr.size()) errs++;
         else if (log_addr[base+i] != exp_addr[i] || log_wr[base+i] != exp_wr[i]) errs++;
      end
      chk({tag, ".seq_errs"}, errs, 0);
   endtask

   initial begin
      int lat, base, s0, ss0;
      for (int i = 0; i < D; i++) begin exp_addr.push_back(AW'(i)); exp_wr.push_back(1'b1); end
      for (int i = 0; i < D; i++) begin
         exp_addr.push_back(AW'(i)); exp_wr.push_back(1'b0);
         exp_addr.push_back(AW'(i)); exp_wr.push_back(1'b1);
      end
      for (int i = D - 1; i >= 0; i--) begin
         exp_addr.push_back(AW'(i)); exp_wr.push_back(1'b0);
         exp_addr.push_back(AW'(i)); exp_wr.push_back(1'b1);
      end
      for (int i = 0; i < D; i++) begin exp_addr.push_back(AW'(i)); exp_wr.push_back(1'b0); end

      #12;
      chk_rst("reset");
      @(negedge clk);
      res = 1'b1;

      run("zw", 0, 1'b0, 0, lat, base);
      chk("zw.latency", lat, 6 * D + 1);
      chk("zw.pass", pass, 1);
      chk("zw.busy", busy, 0);
      chk("zw.valid", mif.valid, 0);
      chk("zw.fail_count", fail_count, 0);
      chk_seq("zw", base);

      run("flt", 0, 1'b1, 0, lat, base);
      chk("flt.latency", lat, 6 * D + 1);
      chk("flt.pass", pass, 0);
`ifdef MEM_BIST_ERR_LOG_EN
      chk("flt.fail_addr", fail_addr, 5);
      chk("flt.fail_count", fail_count, 3);
`else
      chk("flt.fail_addr", fail_addr, 0);
      chk("flt.fail_count", fail_count, 0);
`endif

      s0  = stab_err;
      ss0 = stall_seen;
      run("stl", 3, 1'b0, 0, lat, base);
      chk("stl.latency", lat, 4 * 6 * D + 1);
      chk("stl.pass", pass, 1);
      chk("stl.fail_count", fail_count, 0);
      chk("stl.unstable", stab_err - s0, 0);
      chk("stl.stall_cycles", stall_seen - ss0, 3 * 6 * D);
      chk_seq("stl", base);

      run("busy_start", 0, 1'b0, 50, lat, base);
      chk("busy_start.latency", lat, 6 * D + 1);
      chk("busy_start.pass", pass, 1);
      chk_seq("busy_start", base);

      // Reset in the middle of M2 (ops 96..159 complete at start edge + 97..160).
      stall_n = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (120) @(posedge clk);
      #2;
      chk("mid.in_m2", mif.valid, 1);
      res = 1'b0;
      #1;
      chk_rst("mid_rst");
      @(negedge clk);
      chk_rst("mid_rst_hold");
      res = 1'b1;
      run("after_rst", 0, 1'b0, 0, lat, base);
      chk("after_rst.latency", lat, 6 * D + 1);
      chk("after_rst.pass", pass, 1);
      chk_seq("after_rst", base);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end
endmodule
